modinv_sched: RTL and testbench

MODINV_SCHED -- requirements
Module: modinv_sched

---
 rtl/modinv_sched.sv | 139 +++++++++++++
 tb/tb_modinv_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_sched.sv
// Two-requester scheduler for a shared modular-inverse engine.
// Round-robin arbitration; one job in flight at a time. Even moduli are answered
// locally with an error. Odd moduli are sent to the engine with a bounded wait.
module modinv_sched #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned N_W     = 4096,
  parameter int unsigned INV_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [N_W-1:0]   req0_n,
  input  logic [N_W-1:0]   req1_n,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [INV_W-1:0] rsp0_inv,
  output logic [INV_W-1:0] rsp1_inv,
  output logic             rsp0_err,
  output logic             rsp1_err,
  output logic             eng_go,
  output logic [N_W-1:0]   eng_n,
  input  logic [INV_W-1:0] eng_inv,
  input  logic             eng_valid
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StGo, StWait, StResp} state_e;

  state_e            state_q;
  logic [N_W-1:0]    op_q;
  logic [INV_W-1:0]  inv_q;
  logic              err_q;
  logic [CntW-1:0]   cnt_q;
  logic              gnt_q;   // requester currently being served
  logic              last_q;  // last granted requester; reset to 1 so requester 0 wins a tie
  logic              go_q;
  logic              rsp0_q;
  logic              rsp1_q;

  logic              pick1;
  logic              accept;
  logic [N_W-1:0]    sel_n;

  // Arbitration and request handshake; readiness is blocked by reset in the same cycle.
  always_comb begin
    pick1      = req1_valid & (~req0_valid | ~last_q);
    req0_ready = ~rst & (state_q == StIdle) & ~rsp0_q & ~rsp1_q & req0_valid & ~pick1;
    req1_ready = ~rst & (state_q == StIdle) & ~rsp0_q & ~rsp1_q & pick1;
    accept     = req0_ready | req1_ready;
    sel_n      = pick1 ? req1_n : req0_n;
  end

  // Scheduler FSM with registered engine-start and response-valid outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      inv_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      go_q    <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q   <= sel_n;
            gnt_q  <= pick1;
            last_q <= pick1;
            if (sel_n[0]) begin
              go_q    <= 1'b1;
              state_q <= StGo;
            end else begin
              // Even modulus has no inverse mod 2^k: answer without the engine.
              inv_q   <= '0;
              err_q   <= 1'b1;
              rsp0_q  <= ~pick1;
              rsp1_q  <= pick1;
              state_q <= StResp;
            end
          end
        end
        StGo: begin
          // eng_valid is deliberately not looked at here: it may still belong to the last job.
          go_q    <= 1'b0;
          cnt_q   <= CntW'(1);
          state_q <= StWait;
        end
        StWait: begin
          if (eng_valid) begin
            inv_q   <= eng_inv;
            err_q   <= 1'b0;
            rsp0_q  <= ~gnt_q;
            rsp1_q  <= gnt_q;
            state_q <= StResp;
          end else if (cnt_q == CntW'(TIMEOUT)) begin
            inv_q   <= '0;
            err_q   <= 1'b1;
            rsp0_q  <= ~gnt_q;
            rsp1_q  <= gnt_q;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if ((gnt_q & rsp1_ready) | (~gnt_q & rsp0_ready)) begin
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Response data is forced to zero on any channel that is not holding a response.
  always_comb begin
    eng_go     = go_q;
    eng_n      = op_q;
    rsp0_valid = rsp0_q;
    rsp1_valid = rsp1_q;
    rsp0_inv   = rsp0_q ? inv_q : '0;
    rsp1_inv   = rsp1_q ? inv_q : '0;
    rsp0_err   = rsp0_q & err_q;
    rsp1_err   = rsp1_q & err_q;
  end

endmodule

// File: tb/tb_modinv_sched.sv
// Bench for modinv_sched: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level timing/result model, with a behavioural engine.
module tb_modinv_sched;

  localparam int TIMEOUT = 16;
  localparam int N_W     = 4096;
  localparam int INV_W   = 64;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N_W-1:0]   req0_n, req1_n;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [INV_W-1:0] rsp0_inv, rsp1_inv;
  logic             rsp0_err, rsp1_err;
  logic             eng_go;
  logic [N_W-1:0]   eng_n;
  logic [INV_W-1:0] eng_inv;
  logic             eng_valid;

  modinv_sched #(.TIMEOUT(TIMEOUT), .N_W(N_W), .INV_W(INV_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_n(req0_n), .req1_n(req1_n),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_inv(rsp0_inv), .rsp1_inv(rsp1_inv),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .eng_go(eng_go), .eng_n(eng_n), .eng_inv(eng_inv), .eng_valid(eng_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  // Bit-serial solve of n*y == -1 (mod 2^64).
  function automatic logic [63:0] ref_inv(input logic [63:0] n);
    logic [63:0] y;
    logic [63:0] t;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      t = n * y + 64'd1;
      if (t[i]) y[i] = 1'b1;
    end
    return y;
  endfunction

  // Engine's own method: Newton iteration for n^-1, then negate.
  function automatic logic [63:0] newton_inv(input logic [63:0] n);
    logic [63:0] x;
    x = n;
    for (int i = 0; i < 5; i++) x = x * (64'd2 - n * x);
    return -x;
  endfunction

  function automatic logic [N_W-1:0] rand_n();
    logic [N_W-1:0] n;
    for (int i = 0; i < N_W / 32; i++) n[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0:       n = N_W'(1);
      1:       n = N_W'(3);
      2:       n[0] = 1'b0;
      default: n[0] = 1'b1;
    endcase
    return n;
  endfunction

  function automatic int pick_lat();
    case ($urandom_range(0, 7))
      0:       return 1;
      1:       return TIMEOUT;
      2:       return TIMEOUT + 1;
      3:       return 1000;
      default: return $urandom_range(1, 12);
    endcase
  endfunction

  // Model state: one job, described by when its go pulse and response appear.
  bit             m_on = 0, m_busy = 0, m_last1 = 1, m_k = 0, m_err = 0;
  logic [N_W-1:0] m_op;
  logic [63:0]    m_inv;
  int             m_go_at = -1, m_rsp_at = 0, m_lat = 1, lat_sel = 1;
  bit             acc0 = 0, acc1 = 0, go_prev = 0;
  int             go_cnt = 0;
  bit             g_any, g1, in_rsp;

  // Compare process: predict this cycle's outputs, check them, then advance the model.
  initial forever begin
    @(negedge clk);
    cyc++;
    go_prev = (eng_go === 1'b1);
    if (eng_go === 1'b1) go_cnt++;
    g_any = 0; g1 = 0; in_rsp = 0;
    if (m_on) begin
      g_any  = !m_busy && !rst && (req0_valid || req1_valid);
      g1     = g_any && req1_valid && (!req0_valid || !m_last1);
      in_rsp = m_busy && cyc >= m_rsp_at;
      chk("req0_ready", 64'(req0_ready), 64'(g_any && !g1));
      chk("req1_ready", 64'(req1_ready), 64'(g1));
      chk("eng_go", 64'(eng_go), 64'(m_busy && cyc == m_go_at));
      chk("rsp0_valid", 64'(rsp0_valid), 64'(in_rsp && !m_k));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(in_rsp && m_k));
      chk("rsp0_inv", rsp0_inv, (in_rsp && !m_k) ? m_inv : 64'd0);
      chk("rsp1_inv", rsp1_inv, (in_rsp && m_k) ? m_inv : 64'd0);
      chk("rsp0_err", 64'(rsp0_err), 64'(in_rsp && !m_k && m_err));
      chk("rsp1_err", 64'(rsp1_err), 64'(in_rsp && m_k && m_err));
      if (m_busy && m_go_at >= 0 && cyc >= m_go_at && cyc < m_rsp_at)
        chk("eng_n_stable", 64'(eng_n == m_op), 64'd1);
    end
    acc0 = 0; acc1 = 0;
    if (rst) begin
      m_on = 1; m_busy = 0; m_last1 = 1;
    end else if (m_on) begin
      if (in_rsp && (m_k ? rsp1_ready : rsp0_ready)) begin
        m_busy = 0;
      end else if (g_any) begin
        m_busy = 1; m_k = g1; m_last1 = g1; acc0 = !g1; acc1 = g1;
        m_op = g1 ? req1_n : req0_n;
        if (!m_op[0]) begin
          m_go_at = -1; m_rsp_at = cyc + 1; m_err = 1; m_inv = '0;
        end else begin
          m_go_at = cyc + 1; m_lat = lat_sel;
          if (lat_sel <= TIMEOUT) begin
            m_rsp_at = cyc + 2 + lat_sel; m_err = 0; m_inv = ref_inv(m_op[63:0]);
          end else begin
            m_rsp_at = cyc + 2 + TIMEOUT; m_err = 1; m_inv = '0;
          end
        end
      end
    end
  end

  // Engine: result valid in the lat-th cycle after the go pulse, then held until the next go.
  int          e_cnt = 0, e_lat = 0;
  bit          e_act = 0;
  logic [63:0] e_res;
  initial begin
    eng_valid = 1'b0;
    eng_inv   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (go_prev) begin
        eng_valid = 1'b0; e_cnt = 1; e_act = 1; e_lat = m_lat;
        e_res = newton_inv(eng_n[63:0]);
      end
      if (e_act) begin
        if (e_cnt == e_lat) begin
          eng_valid = 1'b1; eng_inv = e_res; e_act = 0;
        end else begin
          e_cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic wait_acc(input bit k);
    bit seen;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      seen = k ? req1_ready : req0_ready;
    end
    chk("accept", 64'(seen), 64'd1);
  endtask

  task automatic wait_rsp(input bit k, output int dly);
    bit seen;
    seen = 0; dly = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      dly++;
      seen = k ? rsp1_valid : rsp0_valid;
      if (!seen) chk("other_rsp_quiet", 64'(k ? rsp0_valid : rsp1_valid), 64'd0);
    end
    chk("rsp_arrives", 64'(seen), 64'd1);
  endtask

  task automatic ack(input bit k);
    @(posedge clk); #1;
    if (k) rsp1_ready = 1; else rsp0_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic job(input bit k, input logic [N_W-1:0] n, input int lat, input int hold,
                     output logic [63:0] inv, output logic err, output int dly, output int gos);
    int gos0;
    lat_sel = lat;
    @(posedge clk); #1;
    if (k) begin req1_valid = 1; req1_n = n; end
    else   begin req0_valid = 1; req0_n = n; end
    gos0 = go_cnt;
    wait_acc(k);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_rsp(k, dly);
    dly = dly + 1;  // the accept-cycle edge precedes the first counted negedge
    inv = k ? rsp1_inv : rsp0_inv;
    err = k ? rsp1_err : rsp0_err;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_inv", k ? rsp1_inv : rsp0_inv, inv);
    end
    #1 gos = go_cnt - gos0;
    ack(k);
  endtask

  logic [63:0] inv, inv0;
  logic        err;
  int          dly, gos;

  initial begin
    rst = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_n = '0; req1_n = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("reset_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("reset_eng_go", 64'(eng_go), 64'd0);
    chk("reset_eng_n", 64'(eng_n == '0), 64'd1);

    chk("model_inv_n3", ref_inv(64'd3), 64'h5555555555555555);
    chk("model_inv_n1", ref_inv(64'd1), 64'hFFFFFFFFFFFFFFFF);
    chk("model_inv_n5", ref_inv(64'd5), 64'h3333333333333333);

    // wait_rsp counts from the negedge after accept; job() reports cycles from accept.
    job(0, N_W'(3), 3, 2, inv, err, dly, gos);
    chk("n3_inv", inv, 64'h5555555555555555);
    chk("n3_err", 64'(err), 64'd0);
    chk("n3_go_count", 64'(gos), 64'd1);
    chk("n3_latency", 64'(dly), 64'd6);

    job(1, N_W'(1), 1, 0, inv, err, dly, gos);
    chk("n1_inv", inv, 64'hFFFFFFFFFFFFFFFF);
    chk("n1_err", 64'(err), 64'd0);
    chk("n1_min_latency", 64'(dly), 64'd4);

    job(0, N_W'(4), 1, 0, inv, err, dly, gos);
    chk("even_inv", inv, 64'd0);
    chk("even_err", 64'(err), 64'd1);
    chk("even_no_go", 64'(gos), 64'd0);
    chk("even_latency", 64'(dly), 64'd2);

    job(1, N_W'(5), 1000, 0, inv, err, dly, gos);
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_inv", inv, 64'd0);
    chk("timeout_latency", 64'(dly), 64'd19);

    job(0, N_W'(5), TIMEOUT, 0, inv, err, dly, gos);
    chk("tie_err", 64'(err), 64'd0);
    chk("tie_inv", inv, 64'h3333333333333333);
    chk("tie_latency", 64'(dly), 64'd19);

    // Contention straight after reset.
    do_reset();
    lat_sel = 2;
    @(posedge clk); #1;
    req0_valid = 1; req0_n = N_W'(3); req1_valid = 1; req1_n = N_W'(5);
    @(negedge clk);
    chk("cont_first_gnt0", 64'(req0_ready), 64'd1);
    chk("cont_first_not1", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    req0_valid = 0;
    wait_rsp(0, dly);
    inv0 = rsp0_inv;
    chk("cont_rsp0_inv", inv0, 64'h5555555555555555);
    @(posedge clk); #1;
    req0_valid = 1; req0_n = N_W'(7);
    repeat (5) begin
      @(negedge clk);
      chk("cont_rsp0_held", 64'(rsp0_valid), 64'd1);
      chk("cont_rsp0_stable", rsp0_inv, inv0);
      chk("cont_req1_blocked", 64'(req1_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0;
    @(negedge clk);
    chk("cont_gnt1_next", 64'(req1_ready), 64'd1);
    chk("cont_no_preempt", 64'(req0_ready), 64'd0);
    @(posedge clk); #1;
    req1_valid = 0; req0_valid = 0;
    wait_rsp(1, dly);
    chk("cont_rsp1_inv", rsp1_inv, 64'h3333333333333333);
    ack(1);

    // Reset during WAIT; the abandoned job's late engine result must be ignored.
    lat_sel = 4;
    @(posedge clk); #1;
    req0_valid = 1; req0_n = N_W'(7);
    wait_acc(0);
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; req1_valid = 1; req1_n = N_W'(3); lat_sel = 3;
    @(negedge clk);
    chk("reset_blocks_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    wait_acc(1);
    @(posedge clk); #1;
    req1_valid = 0;
    wait_rsp(1, dly);
    chk("after_reset_rsp1_inv", rsp1_inv, 64'h5555555555555555);
    chk("after_reset_rsp1_err", 64'(rsp1_err), 64'd0);
    ack(1);

    // Randomized traffic; the compare process checks every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) == 0);
      if (acc0) req0_valid = 0;
      if (acc1) req1_valid = 0;
      if (!req0_valid && $urandom_range(0, 3) == 0) begin req0_valid = 1; req0_n = rand_n(); end
      if (!req1_valid && $urandom_range(0, 3) == 0) begin req1_valid = 1; req1_n = rand_n(); end
      rsp0_ready = ($urandom_range(0, 2) == 0);
      rsp1_ready = ($urandom_range(0, 2) == 0);
      lat_sel = pick_lat();
    end
    do_reset();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
